// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches words over a req/ack bus, honours stall/flush/branch and keeps the delay slot.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic        run_q, run_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [31:0] drain_addr_q, drain_addr_d;

   logic        req;
   logic [31:0] addr;
   logic [31:0] seq_pc;
   logic [31:0] br_tgt;
   logic        br_take;

   always_comb begin
      state_d      = state_q;
      run_d        = 1'b1;
      pc_d         = pc_q;
      out_pc_d     = out_pc_q;
      out_inst_d   = out_inst_q;
      out_valid_d  = out_valid_q;
      buf_pc_d     = buf_pc_q;
      buf_inst_d   = buf_inst_q;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;
      drain_addr_d = drain_addr_q;

      // run_q keeps the request low for the reset cycle itself
      req     = run_q && (state_q != HOLD);
      addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
      seq_pc  = pend_q ? pend_tgt_q : (pc_q + 32'd4);
      br_tgt  = {branch_target_i[31:2], 2'b00};
      br_take = branch_flag_i && !stall_i;

      if (flush_i) begin
         out_valid_d = 1'b0;
         out_inst_d  = NOP_INST;
         buf_pc_d    = '0;
         buf_inst_d  = '0;
         pend_d      = 1'b0;
         pend_tgt_d  = '0;
         pc_d        = {flush_pc_i[31:2], 2'b00};
         if (req && !inst_ack_i) begin
            drain_addr_d = addr;
            state_d      = DRAIN;
         end else begin
            state_d = FETCH;
         end
      end else if (run_q) begin
         unique case (state_q)
            FETCH: begin
               if (inst_ack_i) begin
                  pc_d   = br_take ? br_tgt : seq_pc;
                  pend_d = 1'b0;
                  if (!stall_i) begin
                     out_pc_d    = pc_q;
                     out_inst_d  = inst_rdata_i;
                     out_valid_d = 1'b1;
                  end else begin
                     buf_pc_d   = pc_q;
                     buf_inst_d = inst_rdata_i;
                     state_d    = HOLD;
                  end
               end else begin
                  // the word at pc is the delay slot; the target is used after it arrives
                  if (br_take) begin
                     pend_d     = 1'b1;
                     pend_tgt_d = br_tgt;
                  end
                  if (!stall_i) begin
                     out_valid_d = 1'b0;
                     out_inst_d  = NOP_INST;
                  end
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  out_pc_d    = buf_pc_q;
                  out_inst_d  = buf_inst_q;
                  out_valid_d = 1'b1;
                  state_d     = FETCH;
                  if (branch_flag_i) begin
                     pc_d = br_tgt;
                  end
               end
            end
            DRAIN: begin
               if (inst_ack_i) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= FETCH;
         run_q        <= 1'b0;
         pc_q         <= {RESET_PC[31:2], 2'b00};
         out_pc_q     <= '0;
         out_inst_q   <= NOP_INST;
         out_valid_q  <= 1'b0;
         buf_pc_q     <= '0;
         buf_inst_q   <= '0;
         pend_q       <= 1'b0;
         pend_tgt_q   <= '0;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         pc_q         <= pc_d;
         out_pc_q     <= out_pc_d;
         out_inst_q   <= out_inst_d;
         out_valid_q  <= out_valid_d;
         buf_pc_q     <= buf_pc_d;
         buf_inst_q   <= buf_inst_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   assign inst_req_o  = req;
   assign inst_addr_o = addr;
   assign pc_o        = out_pc_q;
   assign inst_o      = out_inst_q;
   assign valid_o     = out_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: expected instruction stream kept as a program-order queue,
// a monitor pops it whenever ID consumes a valid word and also checks the bus protocol.
module tb_if_stage;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc_i = '0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_ack_i = 1'b0;
   logic [31:0] inst_rdata_i = '0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   int total = 0;
   int bad   = 0;
   int pops  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] prog_pc = 32'h0;
   logic        last_br = 1'b0;

   int ack_t[8]   = '{100, 30, 70, 100, 50, 90, 40, 100};
   int stall_t[8] = '{0,   20, 40, 0,   30, 10, 50, 25};
   int br_t[8]    = '{0,   20, 30, 25,  15, 40, 20, 30};
   int fl_t[8]    = '{0,   0,  3,  2,   5,  2,  4,  3};

   if_stage #(
      .RESET_PC(32'h0000_0000),
      .NOP_INST(32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .flush_pc_i     (flush_pc_i),
      .branch_flag_i  (branch_flag_i),
      .branch_target_i(branch_target_i),
      .inst_req_o     (inst_req_o),
      .inst_addr_o    (inst_addr_o),
      .inst_ack_i     (inst_ack_i),
      .inst_rdata_i   (inst_rdata_i),
      .pc_o           (pc_o),
      .inst_o         (inst_o),
      .valid_o        (valid_o)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic logic [31:0] pick_target();
      int sel;
      sel = $urandom_range(7);
      case (sel)
         0: pick_target = 32'hFFFF_FFFC;
         1: pick_target = 32'hFFFF_FFF8;
         2: pick_target = 32'h0000_0200;
         3: pick_target = 32'h0000_0180;
         default: pick_target = $urandom;
      endcase
   endfunction

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(prog_pc);
         prog_pc = prog_pc + 32'd4;
      end
   endtask

   // called just after a rising edge: chooses this cycle's inputs and updates the program model
   task automatic drive_cycle(input int ack_pct, input int stall_pct, input int br_pct, input int fl_pct);
      logic [31:0] t;
      stall_i         = ($urandom_range(99) < stall_pct);
      flush_i         = ($urandom_range(99) < fl_pct);
      flush_pc_i      = $urandom;
      branch_flag_i   = 1'b0;
      branch_target_i = $urandom;
      if (flush_i) begin
         t          = pick_target();
         flush_pc_i = t;
         exp_q.delete();
         prog_pc    = {t[31:2], 2'b00};
         last_br    = 1'b0;
      end else if (stall_i) begin
         branch_flag_i = 1'($urandom_range(1));
      end else if (valid_o) begin
         if (!last_br && ($urandom_range(99) < br_pct)) begin
            t               = pick_target();
            branch_flag_i   = 1'b1;
            branch_target_i = t;
            while (exp_q.size() > 2) void'(exp_q.pop_back());
            prog_pc = {t[31:2], 2'b00};
            last_br = 1'b1;
         end else begin
            last_br = 1'b0;
         end
      end
      inst_ack_i   = inst_req_o && ($urandom_range(99) < ack_pct);
      inst_rdata_i = inst_ack_i ? (inst_addr_o ^ KEY) : $urandom;
      refill();
   endtask

   initial begin
      repeat (6) begin
         @(posedge clk);
         #1;
         stall_i         = 1'($urandom_range(1));
         flush_i         = 1'($urandom_range(1));
         flush_pc_i      = $urandom;
         branch_flag_i   = 1'($urandom_range(1));
         branch_target_i = $urandom;
         inst_ack_i      = 1'($urandom_range(1));
         inst_rdata_i    = $urandom;
      end
      @(posedge clk);
      #1;
      stall_i       = 1'b0;
      flush_i       = 1'b0;
      branch_flag_i = 1'b0;
      inst_ack_i    = 1'b0;
      rst           = 1'b1;
      prog_pc       = 32'h0;
      exp_q.delete();
      refill();
      @(posedge clk);
      #1;
      check("req_after_reset", 32'(inst_req_o), 32'h1);
      check("addr_after_reset", inst_addr_o, 32'h0);
      drive_cycle(ack_t[0], stall_t[0], br_t[0], fl_t[0]);
      for (int ph = 0; ph < 8; ph++) begin
         repeat (500) begin
            @(posedge clk);
            #1;
            drive_cycle(ack_t[ph], stall_t[ph], br_t[ph], fl_t[ph]);
         end
      end
      repeat (30) begin
         @(posedge clk);
         #1;
         drive_cycle(100, 0, 0, 0);
      end
      @(negedge clk);
      #1;
      check("progress", 32'(pops >= 200), 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // monitor: bus protocol and IF/ID stream, sampled mid-cycle
   initial begin
      logic        have_prev;
      logic        prev_req, prev_ack, prev_stall, prev_flush, prev_drain;
      logic [31:0] prev_addr;
      logic        draining;
      logic        in_drain;
      logic [31:0] e;
      int          idle;
      have_prev = 1'b0;
      draining  = 1'b0;
      idle      = 0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_flush = 1'b0; prev_drain = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("rst_pc_o", pc_o, 32'h0);
            check("rst_inst_o", inst_o, 32'h0);
            check("rst_valid_o", 32'(valid_o), 32'h0);
            check("rst_req", 32'(inst_req_o), 32'h0);
            have_prev = 1'b0;
            draining  = 1'b0;
         end else begin
            if (have_prev) begin
               if (prev_req && !prev_ack) begin
                  check("req_held", 32'(inst_req_o), 32'h1);
                  check("addr_held", inst_addr_o, prev_addr);
               end
               if (prev_req && prev_ack && prev_stall && !prev_flush && !prev_drain)
                  check("hold_req_low", 32'(inst_req_o), 32'h0);
            end
            if (inst_req_o)
               check("addr_align", 32'(inst_addr_o[1:0]), 32'h0);
            if (!valid_o)
               check("bubble_inst", inst_o, 32'h0);

            in_drain = draining;
            if (flush_i)
               draining = inst_req_o && !inst_ack_i;
            else if (inst_req_o && inst_ack_i)
               draining = 1'b0;

            if (!flush_i && !stall_i && valid_o) begin
               idle = 0;
               if (exp_q.size() == 0) begin
                  check("queue_empty", 32'(exp_q.size()), 32'h1);
               end else begin
                  e = exp_q.pop_front();
                  check("pc_o", pc_o, e);
                  check("inst_o", inst_o, e ^ KEY);
                  pops++;
               end
            end else begin
               idle++;
               if (idle > 300) begin
                  check("watchdog_idle", 32'(idle), 32'h0);
                  idle = 0;
               end
            end

            have_prev  = 1'b1;
            prev_req   = inst_req_o;
            prev_ack   = inst_ack_i;
            prev_addr  = inst_addr_o;
            prev_stall = stall_i;
            prev_flush = flush_i;
            prev_drain = in_drain;
         end
      end
   end

endmodule
